// File: rtl/cam_capture_packer.sv
// Camera capture front end: registers the parallel camera bus, packs href beats into
// sof/eol-tagged words and buffers them in a first-word-fall-through FIFO.
module cam_capture_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int BEATS_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int LINE_CNT_W     = 10,
  parameter int BEAT_CNT_W     = 12
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 cam_vsync,
  input  logic                                 cam_href,
  input  logic [DATA_WIDTH-1:0]                cam_dat,
  input  logic                                 capture_en,
  input  logic                                 single_frame,
  output logic [DATA_WIDTH*BEATS_PER_WORD-1:0] out_data,
  output logic                                 out_sof,
  output logic                                 out_eol,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 frame_done,
  output logic                                 busy,
  output logic                                 overflow,
  input  logic                                 overflow_clr,
  output logic [LINE_CNT_W-1:0]                line_count,
  output logic [BEAT_CNT_W-1:0]                last_line_beats
);

  // state   | meaning
  // IDLE    | capture disabled, waiting for capture_en
  // ARMED   | enabled, waiting for a vsync rising edge to start a frame
  // CAPTURE | packing href beats into the FIFO
  // DONE    | single frame finished, waiting for capture_en to drop

  localparam int WORD_W  = DATA_WIDTH * BEATS_PER_WORD;
  localparam int ENTRY_W = WORD_W + 2;
  localparam int IDX_W   = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS_PER_WORD - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DONE} state_t;

  state_t state_q;
  logic   busy_q;
  logic   frame_done_q;

  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  href_q, href_d;
  logic                  vsync_q, vsync_d;
  logic                  href_d1_q, href_d1_d;
  logic                  vsync_d1_q, vsync_d1_d;

  logic [WORD_W-1:0]     word_q, word_d;
  logic [IDX_W-1:0]      beat_idx_q, beat_idx_d;
  logic                  sof_pend_q, sof_pend_d;
  logic [LINE_CNT_W-1:0] line_count_q, line_count_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BEAT_CNT_W-1:0] last_line_beats_q, last_line_beats_d;

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  logic              vsync_rise;
  logic              href_fall;
  logic              capturing;
  logic              arm_hit;
  logic              push_req;
  logic [WORD_W-1:0] push_word;
  logic              push_sof;
  logic              push_eol;
  logic              fifo_pop;
  logic              fifo_full;
  logic              push_ok;

  assign vsync_rise = vsync_q & ~vsync_d1_q;
  assign href_fall  = ~href_q & href_d1_q;
  assign capturing  = (state_q == ST_CAPTURE) && capture_en;
  assign arm_hit    = (state_q == ST_ARMED) && capture_en && vsync_rise;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (capture_en) begin
            state_q <= ST_ARMED;
            busy_q  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (!capture_en) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (vsync_rise) begin
            state_q <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (!capture_en) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (vsync_rise) begin
            frame_done_q <= 1'b1;
            if (single_frame) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (!capture_en) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    dat_d      = cam_dat;
    href_d     = cam_href;
    vsync_d    = cam_vsync;
    href_d1_d  = href_q;
    vsync_d1_d = vsync_q;
  end

  // A full word takes eol when the live href shows this was the line's final beat,
  // so a line ending on a word boundary is tagged without an extra push.
  always_comb begin
    word_d            = word_q;
    beat_idx_d        = beat_idx_q;
    sof_pend_d        = sof_pend_q;
    line_count_d      = line_count_q;
    beat_cnt_d        = beat_cnt_q;
    last_line_beats_d = last_line_beats_q;
    push_req          = 1'b0;
    push_word         = '0;
    push_sof          = 1'b0;
    push_eol          = 1'b0;
    if (capturing) begin
      if (vsync_rise) begin
        word_d     = '0;
        beat_idx_d = '0;
        beat_cnt_d = '0;
        if (!single_frame) begin
          sof_pend_d   = 1'b1;
          line_count_d = '0;
        end
      end else if (href_q) begin
        for (int s = 0; s < BEATS_PER_WORD; s++) begin
          if (int'(beat_idx_q) == s) word_d[s*DATA_WIDTH +: DATA_WIDTH] = dat_q;
        end
        if (beat_cnt_q != {BEAT_CNT_W{1'b1}}) beat_cnt_d = beat_cnt_q + 1'b1;
        if (beat_idx_q == LAST_IDX) begin
          push_req   = 1'b1;
          push_word  = word_d;
          push_eol   = ~cam_href;
          word_d     = '0;
          beat_idx_d = '0;
        end else begin
          beat_idx_d = beat_idx_q + 1'b1;
        end
      end else if (href_fall) begin
        line_count_d      = line_count_q + 1'b1;
        last_line_beats_d = beat_cnt_q;
        beat_cnt_d        = '0;
        if (beat_idx_q != '0) begin
          push_req   = 1'b1;
          push_word  = word_q;
          push_eol   = 1'b1;
          word_d     = '0;
          beat_idx_d = '0;
        end
      end
      if (push_req) begin
        push_sof   = sof_pend_q;
        sof_pend_d = 1'b0;
      end
    end else begin
      word_d     = '0;
      beat_idx_d = '0;
      beat_cnt_d = '0;
      if (arm_hit) begin
        sof_pend_d   = 1'b1;
        line_count_d = '0;
      end
    end
  end

  // A push into a full FIFO still lands when a pop frees a slot the same cycle.
  always_comb begin
    fifo_pop   = (count_q != '0) && out_ready;
    fifo_full  = (count_q == DEPTH_C);
    push_ok    = push_req && (!fifo_full || fifo_pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {push_sof, push_eol, push_word};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (fifo_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !fifo_pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && fifo_pop) begin
      count_d = count_q - 1'b1;
    end
    if (overflow_clr) overflow_d = 1'b0;
    if (push_req && !push_ok) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dat_q             <= '0;
      href_q            <= 1'b0;
      vsync_q           <= 1'b0;
      href_d1_q         <= 1'b0;
      vsync_d1_q        <= 1'b0;
      word_q            <= '0;
      beat_idx_q        <= '0;
      sof_pend_q        <= 1'b0;
      line_count_q      <= '0;
      beat_cnt_q        <= '0;
      last_line_beats_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      overflow_q        <= 1'b0;
    end else begin
      dat_q             <= dat_d;
      href_q            <= href_d;
      vsync_q           <= vsync_d;
      href_d1_q         <= href_d1_d;
      vsync_d1_q        <= vsync_d1_d;
      word_q            <= word_d;
      beat_idx_q        <= beat_idx_d;
      sof_pend_q        <= sof_pend_d;
      line_count_q      <= line_count_d;
      beat_cnt_q        <= beat_cnt_d;
      last_line_beats_q <= last_line_beats_d;
      mem_q             <= mem_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      overflow_q        <= overflow_d;
    end
  end

  assign out_data        = mem_q[rd_ptr_q][WORD_W-1:0];
  assign out_eol         = mem_q[rd_ptr_q][WORD_W];
  assign out_sof         = mem_q[rd_ptr_q][WORD_W+1];
  assign out_valid       = (count_q != '0);
  assign frame_done      = frame_done_q;
  assign busy            = busy_q;
  assign overflow        = overflow_q;
  assign line_count      = line_count_q;
  assign last_line_beats = last_line_beats_q;

endmodule

// File: doc/cam_capture_packer.md
Name: cam_capture_packer

Overview:
- Parametrised camera capture front end. It samples the parallel camera bus (data, href, vsync) on the camera pixel clock and arms on frame boundaries.
- It packs input beats into wide words tagged with start-of-frame and end-of-line, and buffers them in a FIFO with a valid/ready output.
- It sits between the camera pad registers and the vhdl_top capture DMA.
- It adds what the fixed 8-bit pad capture lacks: width and packing generalisation, frame arming, single-shot mode, overflow detection and line statistics.

Parameters:
- DATA_WIDTH, 8, camera data bus width in bits.
- BEATS_PER_WORD, 4, input beats packed per output word (>=1).
- FIFO_DEPTH, 8, output FIFO entries (power of 2, >=2).
- LINE_CNT_W, 10, width of line counter.
- BEAT_CNT_W, 12, width of per-line beat counter.

Ports:
- clk  in  1  camera pixel clock; the only clock.
- resetn  in  1  synchronous active-low reset.
- cam_vsync  in  1  frame sync; rising edge marks frame boundary.
- cam_href  in  1  line valid; beat captured when high.
- cam_dat  in  DATA_WIDTH  pixel data beat.
- capture_en  in  1  level; enables arming and capture.
- single_frame  in  1  1 = stop after one complete frame.
- out_data  out  DATA_WIDTH*BEATS_PER_WORD  packed word; first beat in LSBs.
- out_sof  out  1  tag: first word of frame.
- out_eol  out  1  tag: last word of line.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts word.
- frame_done  out  1  one-cycle pulse at end of captured frame.
- busy  out  1  high in ARMED or CAPTURE.
- overflow  out  1  sticky: word dropped on full FIFO.
- overflow_clr  in  1  clears overflow.
- line_count  out  LINE_CNT_W  completed lines in current/last frame.
- last_line_beats  out  BEAT_CNT_W  beats in most recent line, saturating.

Behaviour:
- Reset (resetn=0 at clk edge): state=IDLE, FIFO emptied, packer cleared, input regs 0, all outputs 0. Reset mid-frame discards partial data. After release the block re-arms only on a vsync rising edge.
- Input stage: cam_dat/href/vsync registered once.
- Edge detection: vsync_rise and href_fall are detected between the registered value and its one-cycle-delayed copy.
- FSM states: IDLE, ARMED, CAPTURE, DONE.
  - IDLE -> ARMED when capture_en=1.
  - ARMED -> CAPTURE on vsync_rise. This clears line_count and sets the pending-sof flag.
  - CAPTURE, on vsync_rise: pulse frame_done. If single_frame=1 -> DONE. Otherwise remain in CAPTURE as a new frame (line_count cleared, sof pending).
  - DONE -> IDLE when capture_en=0.
  - capture_en=0 in ARMED or CAPTURE -> IDLE next cycle. The partial word is discarded and FIFO contents are retained for draining.
- Packing (CAPTURE only):
  - Each registered beat with href=1 goes to slot beat_idx, bits [beat_idx*DATA_WIDTH +: DATA_WIDTH], and beat_idx increments.
  - When beat_idx reaches BEATS_PER_WORD-1 the word is pushed and beat_idx resets to 0.
  - On href_fall with beat_idx>0, the partial word is pushed with unused upper slots 0.
  - The word pushed on href_fall, or the last full word before it, carries eol=1.
  - The first word pushed after sof pending carries sof=1, then sof pending clears.
  - Full word completing in the same cycle as href_fall: one push, eol=1.
- Latency: a beat presented at edge t that completes a word produces out_valid=1 after edge t+1, when the FIFO was empty.
- FIFO:
  - First-word-fall-through. out_data/out_sof/out_eol are valid whenever out_valid=1. Pop when out_valid & out_ready.
  - Push is accepted if count<FIFO_DEPTH or a pop occurs the same cycle. Otherwise the word is dropped and overflow sets.
  - Simultaneous overflow set and overflow_clr: set wins.
  - Pointers wrap modulo FIFO_DEPTH.
- Counters:
  - line_count increments on each href_fall in CAPTURE and wraps at 2^LINE_CNT_W.
  - A per-line beat counter counts href beats and saturates at all-ones. On href_fall it is copied to last_line_beats and cleared.
- busy = state in {ARMED, CAPTURE}.

Test Plan:
- Defaults, capture_en=1, vsync pulse, href high 4 beats 0x11,0x22,0x33,0x44 -> one word out_data=0x44332211, out_sof=1, out_eol=1; line_count=1; last_line_beats=4.
- Line of 6 beats 0x11..0x66 -> words 0x44332211 (sof=1, eol=0) and 0x00006655 (sof=0, eol=1).
- out_ready=0, frame of 9 full words (FIFO_DEPTH=8) -> 8 words held, overflow=1. Raise out_ready -> exactly 8 words drain in order. overflow_clr -> overflow=0.
- single_frame=1, two frames sent -> frame_done pulses once at second vsync rise, state DONE, no second-frame words. Drop capture_en -> IDLE, busy=0.
- capture_en=1 asserted mid-frame with href active -> no words until next vsync rise, then first word has sof=1.
- resetn=0 for one cycle after 2 beats of a line -> out_valid=0, overflow=0, line_count=0. Subsequent href data ignored until the next vsync rise.
